// File: rtl/serial_frame_tx_pkg.sv
// Shared constants for the serial frame transmitter: FSM encodings, line levels
// and a width helper used by the FSM and the bit timer.
package serial_frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Counter/index width for a range of n values, never narrower than 1 bit.
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Parallel word handshake into the serial frame transmitter: the sender offers
// tx_data with tx_valid and the word is taken on an edge where tx_ready is high.
interface serial_frame_tx_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer: bit_end marks the last cycle of each BIT_CYCLES-long bit;
// restart holds the count at zero so the next bit starts a full period later.
module tx_bit_timer
    import serial_frame_tx_pkg::*;
#(
    parameter int BIT_CYCLES = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic bit_end
);
    localparam int             CNT_W    = min1_clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    assign bit_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (restart || bit_end) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start, DATA_W bits LSB-first, optional parity, stop.
// Start bit appears the cycle after acceptance; tx_ready stays low for the whole frame.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 1,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic             clock,
    input  logic             reset,
    serial_frame_tx_if.slave tx,
    output logic             x_out,
    output logic             busy,
    output logic             done
);
    localparam int               IDX_W    = min1_clog2(DATA_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    tx_state_t         state_q, state_nxt;
    logic [DATA_W-1:0] shift_q, shift_nxt;
    logic [IDX_W-1:0]  idx_q, idx_nxt;
    logic              parity_q, parity_nxt;
    logic              x_q, x_nxt;
    logic              ready_q, ready_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;
    logic              bit_end;

    tx_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .restart (state_q == ST_IDLE),
        .bit_end (bit_end)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            x_q      <= LINE_IDLE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            shift_q  <= shift_nxt;
            idx_q    <= idx_nxt;
            parity_q <= parity_nxt;
            x_q      <= x_nxt;
            ready_q  <= ready_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        shift_nxt  = shift_q;
        idx_nxt    = idx_q;
        parity_nxt = parity_q;
        ready_nxt  = ready_q;
        busy_nxt   = busy_q;
        done_nxt   = 1'b0;
        x_nxt      = LINE_IDLE;

        case (state_q)
            ST_IDLE: begin
                if (tx.tx_valid) begin
                    shift_nxt  = tx.tx_data;
                    parity_nxt = (^tx.tx_data) ^ PARITY_ODD[0];
                    idx_nxt    = '0;
                    state_nxt  = ST_START;
                    ready_nxt  = 1'b0;
                    busy_nxt   = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_nxt = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        idx_nxt   = '0;
                        state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_nxt = idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_nxt = ST_IDLE;
                    ready_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                ready_nxt = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase

        // The line level is registered from the next state so x_out leads nothing combinationally.
        case (state_nxt)
            ST_START:  x_nxt = LINE_START;
            ST_DATA:   x_nxt = shift_nxt[0];
            ST_PARITY: x_nxt = parity_nxt;
            default:   x_nxt = LINE_IDLE;
        endcase
    end

    assign tx.tx_ready = ready_q;
    assign x_out       = x_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed and random frame checks on four transmitter configurations sharing one clock and reset.
module tb_serial_frame_tx;
    import serial_frame_tx_pkg::*;

    logic       clock;
    logic       reset;
    logic [7:0] tb_data;
    logic       tb_valid;
    int         sel;
    int         n_checks;
    int         n_errors;

    logic x_a, x_b, x_c, x_d;
    logic busy_a, busy_b, busy_c, busy_d;
    logic done_a, done_b, done_c, done_d;
    logic cur_x, cur_busy, cur_done, cur_ready;

    serial_frame_tx_if #(.DATA_W(8)) if_a ();
    serial_frame_tx_if #(.DATA_W(8)) if_b ();
    serial_frame_tx_if #(.DATA_W(8)) if_c ();
    serial_frame_tx_if #(.DATA_W(8)) if_d ();

    assign if_a.tx_data  = tb_data;
    assign if_b.tx_data  = tb_data;
    assign if_c.tx_data  = tb_data;
    assign if_d.tx_data  = tb_data;
    assign if_a.tx_valid = tb_valid && (sel == 0);
    assign if_b.tx_valid = tb_valid && (sel == 1);
    assign if_c.tx_valid = tb_valid && (sel == 2);
    assign if_d.tx_valid = tb_valid && (sel == 3);

    serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(1), .PARITY_EN(1), .PARITY_ODD(0)) dut_a (
        .clock(clock), .reset(reset), .tx(if_a), .x_out(x_a), .busy(busy_a), .done(done_a));
    serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(1), .PARITY_EN(1), .PARITY_ODD(1)) dut_b (
        .clock(clock), .reset(reset), .tx(if_b), .x_out(x_b), .busy(busy_b), .done(done_b));
    serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(1), .PARITY_EN(0), .PARITY_ODD(0)) dut_c (
        .clock(clock), .reset(reset), .tx(if_c), .x_out(x_c), .busy(busy_c), .done(done_c));
    serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_d (
        .clock(clock), .reset(reset), .tx(if_d), .x_out(x_d), .busy(busy_d), .done(done_d));

    always_comb begin
        cur_x = x_a; cur_busy = busy_a; cur_done = done_a; cur_ready = if_a.tx_ready;
        case (sel)
            1: begin cur_x = x_b; cur_busy = busy_b; cur_done = done_b; cur_ready = if_b.tx_ready; end
            2: begin cur_x = x_c; cur_busy = busy_c; cur_done = done_c; cur_ready = if_c.tx_ready; end
            3: begin cur_x = x_d; cur_busy = busy_d; cur_done = done_d; cur_ready = if_d.tx_ready; end
            default: ;
        endcase
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge of the done cycle.
    // bits[i] is the i-th bit period on the line, bit 0 being the start bit.
    task automatic run_frame(input logic [7:0] d, input logic [7:0] d_mid, input bit hold,
                             output logic [10:0] bits, output int done_at, output int wait_cyc);
        int bc, nb, f, bi, glitch, hs_bad;
        bc = (sel == 3) ? 4 : 1;
        nb = (sel == 2) ? 10 : 11;
        f  = nb * bc;
        tb_data  = d;
        tb_valid = 1'b1;
        wait_cyc = 0;
        while (cur_ready !== 1'b1 && wait_cyc < 100) begin
            @(negedge clock);
            wait_cyc++;
        end
        if (wait_cyc >= 100) check("accept_wait", wait_cyc, 0);
        @(posedge clock);
        #1 tb_valid = hold;
        bits = '0; done_at = 0; glitch = 0; hs_bad = 0;
        for (int j = 1; j <= f + 1; j++) begin
            @(negedge clock);
            if (j <= f) begin
                bi = (j - 1) / bc;
                if ((j - 1) % bc == 0) bits[bi] = cur_x;
                else if (cur_x !== bits[bi]) glitch++;
                if (cur_ready !== 1'b0 || cur_busy !== 1'b1) hs_bad++;
            end else if (cur_x !== 1'b1) begin
                glitch++;
            end
            if (cur_done === 1'b1 && done_at == 0) done_at = j;
            if (j == 3) tb_data = d_mid;
        end
        check("bit_hold", glitch, 0);
        check("handshake", hs_bad, 0);
    endtask

    logic [10:0] bits;
    int          done_at, wait_cyc, rd;
    logic [7:0]  rd_data;

    initial begin
        n_checks = 0; n_errors = 0;
        reset = 1'b0; sel = 0; tb_valid = 1'b0; tb_data = 8'h00;
        #12;
        check("rst_x", cur_x, 1);
        check("rst_ready", cur_ready, 1);
        check("rst_busy", cur_busy, 0);
        check("rst_done", cur_done, 0);
        @(negedge clock) reset = 1'b1;
        @(negedge clock);

        sel = 0;
        run_frame(8'hA5, 8'hA5, 0, bits, done_at, wait_cyc);
        check("a5_bits", bits, 11'b10101001010);
        check("a5_done", done_at, 12);

        sel = 1;
        run_frame(8'h00, 8'h00, 0, bits, done_at, wait_cyc);
        check("odd00_bits", bits, 11'b11000000000);
        check("odd00_done", done_at, 12);

        sel = 2;
        run_frame(8'h00, 8'h00, 0, bits, done_at, wait_cyc);
        check("nopar_bits", bits, 11'b01000000000);
        check("nopar_done", done_at, 11);

        sel = 3;
        run_frame(8'hFF, 8'hFF, 0, bits, done_at, wait_cyc);
        check("bc4_bits", bits, 11'b10111111110);
        check("bc4_done", done_at, 45);

        // Held valid: data changes mid-frame, next word taken on the done edge.
        sel = 0;
        run_frame(8'h3C, 8'hC3, 1, bits, done_at, wait_cyc);
        check("b2b1_bits", bits, 11'b10001111000);
        check("b2b1_done", done_at, 12);
        run_frame(8'hC3, 8'hC3, 0, bits, done_at, wait_cyc);
        check("b2b2_wait", wait_cyc, 0);
        check("b2b2_bits", bits, 11'b10110000110);
        check("b2b2_done", done_at, 12);

        // Reset asserted during the third data bit.
        tb_data = 8'h00; tb_valid = 1'b1;
        @(posedge clock);
        #1 tb_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1 check("pre_rst_x", cur_x, 0);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_x", cur_x, 1);
        check("mid_rst_ready", cur_ready, 1);
        check("mid_rst_busy", cur_busy, 0);
        check("mid_rst_done", cur_done, 0);
        @(negedge clock);
        @(negedge clock) reset = 1'b1;
        rd = 0;
        repeat (3) begin
            @(negedge clock);
            if (cur_done !== 1'b0 || cur_x !== 1'b1) rd++;
        end
        check("post_rst_idle", rd, 0);
        run_frame(8'h5A, 8'h5A, 0, bits, done_at, wait_cyc);
        check("5a_bits", bits, 11'b10010110100);
        check("5a_done", done_at, 12);

        // Random words decoded by a reference deserializer from the sampled bit periods.
        for (int i = 0; i < 200; i++) begin
            sel = i % 4;
            rd_data = 8'($urandom);
            run_frame(rd_data, rd_data, 0, bits, done_at, wait_cyc);
            check("rand_data", bits[8:1], rd_data);
            check("rand_start", bits[0], 0);
            if (sel == 2) begin
                check("rand_stop", bits[9], 1);
                check("rand_done", done_at, 11);
            end else begin
                check("rand_par", bits[9], (^rd_data) ^ (sel == 1));
                check("rand_stop", bits[10], 1);
                check("rand_done", done_at, (sel == 3) ? 45 : 12);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter that accepts a parallel word over a valid/ready handshake and drives it onto the single-bit serial line `x_out` as a framed bit stream: start bit, data LSB-first, optional parity, then stop bit. It is the sending end for the team's single-input serial receiver/detector state machines. Its output connects directly to their `x_in`, sharing the same `clock` and `reset`.

## Interface
- `DATA_W`, default 8: data bits per frame, minimum 1.
- `BIT_CYCLES`, default 1: clock cycles per serial bit, minimum 1.
- `PARITY_EN`, default 1: 1 appends a parity bit; 0 omits it.
- `PARITY_ODD`, default 0: 0 selects even parity; 1 selects odd parity.

- `clock`  input  1: clock; all state changes on the rising edge.
- `reset`  input  1: asynchronous, active-low reset.
- `tx_data`  input  DATA_W: word to send; sampled only on acceptance.
- `tx_valid`  input  1: sender offers `tx_data`.
- `tx_ready`  output  1: block can accept a word; registered.
- `x_out`  output  1: serial line, registered; idles high.
- `busy`  output  1: frame in progress; registered.
- `done`  output  1: one-cycle pulse after a frame's stop bit completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, with a 3-bit encoding.
- Reset (asynchronous, `reset`=0):
  - state=IDLE, `x_out`=1, `tx_ready`=1, `busy`=0, `done`=0.
  - Bit-period counter, bit index and shift register all cleared.
- IDLE:
  - `x_out`=1, `tx_ready`=1.
  - On an edge with `tx_valid`=1, latch `tx_data` into the shift register, compute the parity bit and go to START.
  - `tx_ready` and `busy` update on that same edge.
- START: `x_out`=0 for one bit period, then go to DATA.
- DATA:
  - `x_out` = shift register bit 0; shift right once at the end of each bit period.
  - After DATA_W bits, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY:
  - `x_out` = XOR of all latched data bits, XOR PARITY_ODD.
  - Holds for one bit period, then goes to STOP.
- STOP:
  - `x_out`=1 for one bit period.
  - Then go to IDLE with `done`=1 for exactly one cycle.
- Bit period:
  - Counter runs 0..BIT_CYCLES-1.
  - The state or bit advances on the edge where the counter equals BIT_CYCLES-1, and the counter wraps to 0 on that edge.
  - Counter width is clog2(BIT_CYCLES), minimum 1 bit.
- Handshake:
  - `tx_ready`=0 and `busy`=1 from the acceptance edge through the STOP state.
  - While `tx_ready`=0, `tx_valid` and `tx_data` are ignored; a held `tx_valid` is not queued.
  - Changes to `tx_data` after acceptance do not affect the frame in flight.
- Back-to-back frames:
  - IDLE always lasts at least one cycle between frames.
  - If `tx_valid` is high during the `done` cycle, the next word is accepted on that edge, so consecutive frames are separated by exactly one idle-high cycle.
- Reset mid-frame: the frame is aborted immediately, `x_out` returns to 1 asynchronously, no `done` is produced, and no partial state survives.

## Timing
- Acceptance edge k:
  - `x_out`=0 (start bit) during cycles k+1 .. k+BIT_CYCLES.
  - Each following bit occupies the next BIT_CYCLES cycles.
- Frame length F = (2 + DATA_W + PARITY_EN) * BIT_CYCLES cycles, start bit through stop bit.
- `done`=1 in cycle k+F+1, the same cycle `tx_ready` returns to 1.
- Maximum throughput: one frame per F+1 cycles.
- `x_out` has no combinational path from any input.

## Structure
- A shared constants include holds the state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4), the idle line level (1) and the start level (0).
- Sub-module `tx_bit_timer`:
  - Parameter BIT_CYCLES; input `restart`; output `bit_end`.
  - Owns the bit-period counter.
  - The main FSM owns the state, bit index, shift register and outputs.

## Test plan
- DATA_W=8, BIT_CYCLES=1, even parity, send 8'hA5:
  - `x_out` from k+1 is 0,1,0,1,0,0,1,0,1,0,1.
  - `done`=1 at k+12.
- PARITY_ODD=1, send 8'h00: data bits all 0, parity bit 1, stop 1. PARITY_EN=0 with 8'h00: frame is 10 bits, `done` at k+11.
- BIT_CYCLES=4, send 8'hFF: start low for exactly 4 cycles, each bit held 4 cycles, `done` at k+45.
- Hold `tx_valid`=1 with 8'h3C then 8'hC3 changed mid-frame:
  - First frame carries 8'h3C.
  - 8'hC3 is accepted on the `done` edge.
  - Exactly one idle-high cycle separates the frames.
- Assert `reset`=0 during the third data bit:
  - `x_out`=1, `tx_ready`=1, `busy`=0 immediately, no `done`.
  - After release, a new 8'h5A frame is sent correctly.
- Random words over 200 frames are checked against a reference deserializer, with zero mismatches.
